// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver.
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int CLKS_PER_BIT_DEFAULT = 434;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_t;

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchronizer for asynchronous inputs; resets to RST_VAL.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= RST_VAL;
            r_q    <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first; mid-bit sampling with glitch, framing and overrun detection.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       full,
    output logic [7:0] data,
    output logic       data_vld,
    output logic       frm_err,
    output logic       ovr_err,
    output logic       busy
);

    localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
    localparam logic [15:0] HALF_M1  = 16'(HALF_BIT - 1);
    localparam logic [15:0] BIT_M1   = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  LAST_IDX = 3'(DATA_BITS - 1);

    logic                 w_rxs;

    state_t               r_state,   w_state_nxt;
    logic [15:0]          r_bit_cnt, w_bit_cnt_nxt;
    logic [2:0]           r_idx,     w_idx_nxt;
    logic [DATA_BITS-1:0] r_shift,   w_shift_nxt;
    logic [DATA_BITS-1:0] r_data,    w_data_nxt;
    logic                 r_vld,     w_vld_nxt;
    logic                 r_frm,     w_frm_nxt;
    logic                 r_ovr,     w_ovr_nxt;
    logic                 r_busy;

    sync_2ff #(
        .RST_VAL(1'b1)
    ) u_sync_rx (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .i_d    (rx),
        .o_q    (w_rxs)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_idx     <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_vld     <= 1'b0;
            r_frm     <= 1'b0;
            r_ovr     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_idx     <= w_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_data    <= w_data_nxt;
            r_vld     <= w_vld_nxt;
            r_frm     <= w_frm_nxt;
            r_ovr     <= w_ovr_nxt;
            r_busy    <= (w_state_nxt != IDLE);
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt + 16'd1;
        w_idx_nxt     = r_idx;
        w_shift_nxt   = r_shift;
        w_data_nxt    = r_data;
        w_vld_nxt     = 1'b0;
        w_frm_nxt     = 1'b0;
        w_ovr_nxt     = 1'b0;

        case (r_state)
            IDLE: begin
                w_bit_cnt_nxt = '0;
                if (!w_rxs) begin
                    w_state_nxt = START;
                end
            end
            START: begin
                if (r_bit_cnt == HALF_M1) begin
                    w_bit_cnt_nxt = '0;
                    w_idx_nxt     = '0;
                    w_state_nxt   = w_rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (r_bit_cnt == BIT_M1) begin
                    w_bit_cnt_nxt = '0;
                    w_shift_nxt   = {w_rxs, r_shift[DATA_BITS-1:1]};
                    w_idx_nxt     = r_idx + 3'd1;
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                // Leave mid-stop-bit so a start edge with zero idle bits is still caught.
                if (r_bit_cnt == BIT_M1) begin
                    w_bit_cnt_nxt = '0;
                    if (!w_rxs) begin
                        w_frm_nxt   = 1'b1;
                        w_state_nxt = BRK;
                    end else if (full) begin
                        w_ovr_nxt   = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_data_nxt  = r_shift;
                        w_vld_nxt   = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
            end
            BRK: begin
                w_bit_cnt_nxt = '0;
                if (w_rxs) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_bit_cnt_nxt = '0;
                w_state_nxt   = IDLE;
            end
        endcase
    end

    assign data     = r_data;
    assign data_vld = r_vld;
    assign frm_err  = r_frm;
    assign ovr_err  = r_ovr;
    assign busy     = r_busy;

endmodule
